// File: rtl/prm_obstacle_scan.sv
// -----------------------------------------------------------------------------
// prm_obstacle_scan
//
// Streams a set of 15-bit obstacle voxel codes to a bank of edge checkers and
// accumulates which edges are blocked by any obstacle in the set.
//
// Each accepted code is registered onto chk_code and broadcast to every
// checker. The checkers answer combinationally on chk_mask, and that answer
// is folded into blocked on the following cycle, so the code and its mask are
// always paired exactly one cycle apart.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a scan (only looked at in IDLE)
//   abort             drop the current scan (SCAN/DRAIN), no done pulse
//   obs_valid/ready   obstacle code input handshake
//   obs_code          obstacle voxel code
//   obs_last          final code of the obstacle set (qualified by obs_valid)
//   chk_code          registered code broadcast to all checkers
//   chk_mask          edge_mask returns, bit i from checker i
//   blocked           OR of all chk_mask returns over the set
//   busy              scan in progress (SCAN or DRAIN)
//   done              one-cycle pulse, blocked/obs_count are final
//   obs_count         codes accepted in the current/last scan (saturating)
//   dbg_state         current FSM state (0 IDLE, 1 SCAN, 2 DRAIN, 3 DONE)
//
// Handshake: a code is transferred on a rising edge where obs_valid and
// obs_ready are both high. obs_ready is high only in SCAN and is dropped in a
// cycle where abort is asserted, so a raised valid/ready pair always means
// the code is taken; obs_code/obs_last are ignored whenever obs_valid is low.
// -----------------------------------------------------------------------------
module prm_obstacle_scan #(
    parameter int NUM_EDGES = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 obs_valid,
    output logic                 obs_ready,
    input  logic [14:0]          obs_code,
    input  logic                 obs_last,
    output logic [14:0]          chk_code,
    input  logic [NUM_EDGES-1:0] chk_mask,
    output logic [NUM_EDGES-1:0] blocked,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     obs_count,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic pend_q;   // chk_code changed last edge; its mask is on chk_mask now
    logic accept;   // code transferred on this edge
    logic fold;     // OR chk_mask into blocked on this edge
    logic clear;    // start of a new scan

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next state and control decode
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        obs_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        fold      = 1'b0;
        clear     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = SCAN;
                end
            end

            SCAN: begin
                busy = 1'b1;
                if (abort) begin
                    // Pending mask is dropped: fold stays low.
                    state_d = IDLE;
                end else begin
                    obs_ready = 1'b1;
                    fold      = pend_q;
                    if (obs_valid) begin
                        accept = 1'b1;
                        if (obs_last) begin
                            state_d = DRAIN;
                        end
                    end
                end
            end

            DRAIN: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    // The final code was accepted last edge, so pend_q is set.
                    fold    = pend_q;
                    state_d = DONE;
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_code  <= '0;
            pend_q    <= 1'b0;
            blocked   <= '0;
            obs_count <= '0;
        end else begin
            // A mask is pending only for the cycle right after an accept.
            pend_q <= accept;

            if (accept) begin
                chk_code <= obs_code;
            end

            if (clear) begin
                obs_count <= '0;
            end else if (accept && (obs_count != {CNT_W{1'b1}})) begin
                obs_count <= obs_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            if (clear) begin
                blocked <= '0;
            end else if (fold) begin
                blocked <= blocked | chk_mask;
            end
        end
    end

    assign dbg_state = state_q;

endmodule
